// File: rtl/alu_decode_stage.sv
// MIPS-to-ALU control decoder behind a 2-entry skid buffer (output reg + skid reg).
// Define ALU_DECODE_ILLEGAL_CNT_EN to add the saturating illegal_cnt output.
module alu_decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [5:0]  out_alufun,
    output logic        out_sign,
    output logic        out_src_b_imm,
    output logic        out_src_a_shamt,
    output logic        out_lui,
    output logic        out_illegal
`ifdef ALU_DECODE_ILLEGAL_CNT_EN
    ,
    output logic [15:0] illegal_cnt
`endif
);

    typedef struct packed {
        logic [5:0] alufun;
        logic       sign;
        logic       src_b_imm;
        logic       src_a_shamt;
        logic       lui;
        logic       illegal;
    } ctrl_t;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    localparam logic [5:0] F_ADD = 6'b000000;
    localparam logic [5:0] F_SUB = 6'b000001;
    localparam logic [5:0] F_AND = 6'b011000;
    localparam logic [5:0] F_OR  = 6'b011110;
    localparam logic [5:0] F_XOR = 6'b010110;
    localparam logic [5:0] F_NOR = 6'b010001;
    localparam logic [5:0] F_SLL = 6'b100000;
    localparam logic [5:0] F_SRL = 6'b100001;
    localparam logic [5:0] F_SRA = 6'b100011;
    localparam logic [5:0] F_EQ  = 6'b110011;
    localparam logic [5:0] F_NEQ = 6'b110001;
    localparam logic [5:0] F_LT  = 6'b110101;
    localparam logic [5:0] F_LEZ = 6'b111101;
    localparam logic [5:0] F_LTZ = 6'b111011;
    localparam logic [5:0] F_GTZ = 6'b111111;

    function automatic ctrl_t mk(input logic [5:0] f, input logic s,
                                 input logic imm, input logic sh,
                                 input logic lu);
        ctrl_t c;
        c.alufun      = f;
        c.sign        = s;
        c.src_b_imm   = imm;
        c.src_a_shamt = sh;
        c.lui         = lu;
        c.illegal     = 1'b0;
        return c;
    endfunction

    logic [5:0] opcode;
    logic [4:0] rt;
    logic [5:0] funct;
    logic       unused_bits;
    ctrl_t      dec;

    assign opcode      = in_instr[31:26];
    assign rt          = in_instr[20:16];
    assign funct       = in_instr[5:0];
    assign unused_bits = ^{in_instr[25:21], in_instr[15:6]};

    always_comb begin
        dec         = '0;
        dec.alufun  = F_ADD;
        dec.illegal = 1'b1;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20: dec = mk(F_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
                    6'h21: dec = mk(F_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
                    6'h22: dec = mk(F_SUB, 1'b1, 1'b0, 1'b0, 1'b0);
                    6'h23: dec = mk(F_SUB, 1'b0, 1'b0, 1'b0, 1'b0);
                    6'h24: dec = mk(F_AND, 1'b0, 1'b0, 1'b0, 1'b0);
                    6'h25: dec = mk(F_OR,  1'b0, 1'b0, 1'b0, 1'b0);
                    6'h26: dec = mk(F_XOR, 1'b0, 1'b0, 1'b0, 1'b0);
                    6'h27: dec = mk(F_NOR, 1'b0, 1'b0, 1'b0, 1'b0);
                    6'h2A: dec = mk(F_LT,  1'b1, 1'b0, 1'b0, 1'b0);
                    6'h2B: dec = mk(F_LT,  1'b0, 1'b0, 1'b0, 1'b0);
                    6'h00: dec = mk(F_SLL, 1'b0, 1'b0, 1'b1, 1'b0);
                    6'h02: dec = mk(F_SRL, 1'b0, 1'b0, 1'b1, 1'b0);
                    6'h03: dec = mk(F_SRA, 1'b0, 1'b0, 1'b1, 1'b0);
                    6'h08: dec = mk(F_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
                    default: ;
                endcase
            end
            6'h08: dec = mk(F_ADD, 1'b1, 1'b1, 1'b0, 1'b0);
            6'h09: dec = mk(F_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
            6'h0C: dec = mk(F_AND, 1'b0, 1'b1, 1'b0, 1'b0);
            6'h0D: dec = mk(F_OR,  1'b0, 1'b1, 1'b0, 1'b0);
            6'h0A: dec = mk(F_LT,  1'b1, 1'b1, 1'b0, 1'b0);
            6'h0B: dec = mk(F_LT,  1'b0, 1'b1, 1'b0, 1'b0);
            6'h23: dec = mk(F_ADD, 1'b1, 1'b1, 1'b0, 1'b0);
            6'h2B: dec = mk(F_ADD, 1'b1, 1'b1, 1'b0, 1'b0);
            // LUI runs as a left shift of the immediate by a constant 16
            6'h0F: dec = mk(F_SLL, 1'b0, 1'b1, 1'b0, 1'b1);
            6'h04: dec = mk(F_EQ,  1'b1, 1'b0, 1'b0, 1'b0);
            6'h05: dec = mk(F_NEQ, 1'b1, 1'b0, 1'b0, 1'b0);
            6'h06: dec = mk(F_LEZ, 1'b1, 1'b0, 1'b0, 1'b0);
            6'h07: dec = mk(F_GTZ, 1'b1, 1'b0, 1'b0, 1'b0);
            6'h01: begin
                if (rt == 5'd0) dec = mk(F_LTZ, 1'b1, 1'b0, 1'b0, 1'b0);
            end
            default: ;
        endcase
    end

    logic [1:0] state;
    logic [1:0] state_nx;
    ctrl_t      out_q;
    ctrl_t      skid_q;
    logic       in_xfer;
    logic       out_xfer;
    logic       load_out;
    logic       load_skid;
    logic       from_skid;

    assign out_valid = (state != EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        state_nx  = state;
        load_out  = 1'b0;
        load_skid = 1'b0;
        from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_nx = ONE;
                    load_out = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && !out_xfer) begin
                    state_nx  = TWO;
                    load_skid = 1'b1;
                end else if (in_xfer) begin
                    load_out = 1'b1;
                end else if (out_xfer) begin
                    state_nx = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    state_nx  = ONE;
                    load_out  = 1'b1;
                    from_skid = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
            out_q    <= '0;
            skid_q   <= '0;
        end else begin
            state    <= state_nx;
            in_ready <= (state_nx != TWO);
            if (load_out) out_q <= from_skid ? skid_q : dec;
            if (load_skid) skid_q <= dec;
        end
    end

    assign out_alufun      = out_q.alufun;
    assign out_sign        = out_q.sign;
    assign out_src_b_imm   = out_q.src_b_imm;
    assign out_src_a_shamt = out_q.src_a_shamt;
    assign out_lui         = out_q.lui;
    assign out_illegal     = out_q.illegal;

`ifdef ALU_DECODE_ILLEGAL_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_cnt <= 16'h0000;
        end else if (out_xfer && out_q.illegal && illegal_cnt != 16'hFFFF) begin
            illegal_cnt <= illegal_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Randomised scoreboard bench for alu_decode_stage: table-driven decode model
// plus a FIFO of expected words; directed scenarios pin the model with literals.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  out_alufun;
    logic        out_sign;
    logic        out_src_b_imm;
    logic        out_src_a_shamt;
    logic        out_lui;
    logic        out_illegal;
`ifdef ALU_DECODE_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt;
`endif

    alu_decode_stage dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_instr(in_instr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_alufun(out_alufun),
        .out_sign(out_sign),
        .out_src_b_imm(out_src_b_imm),
        .out_src_a_shamt(out_src_a_shamt),
        .out_lui(out_lui),
        .out_illegal(out_illegal)
`ifdef ALU_DECODE_ILLEGAL_CNT_EN
        ,
        .illegal_cnt(illegal_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected word: {alufun, sign, src_b_imm, src_a_shamt, lui, illegal}
    typedef struct {
        bit       by_funct;
        bit [5:0] code;
        bit       need_rt0;
        bit [10:0] word;
    } entry_t;

    entry_t table_q[$];

    function automatic void add(bit by_funct, bit [5:0] code, bit rt0,
                                bit [5:0] fun, bit s, bit imm, bit sh, bit lu);
        entry_t e;
        e.by_funct = by_funct;
        e.code     = code;
        e.need_rt0 = rt0;
        e.word     = {fun, s, imm, sh, lu, 1'b0};
        table_q.push_back(e);
    endfunction

    function automatic bit [10:0] model(bit [31:0] ins);
        bit [5:0] op = ins[31:26];
        foreach (table_q[i]) begin
            if (table_q[i].by_funct) begin
                if (op == 6'h00 && ins[5:0] == table_q[i].code) return table_q[i].word;
            end else if (op == table_q[i].code) begin
                if (!table_q[i].need_rt0 || ins[20:16] == 5'd0) return table_q[i].word;
            end
        end
        return 11'b000000_0000_1;
    endfunction

    bit [10:0] q[$];
    bit        armed = 0;
    bit        chk_en = 0;
    int        cnt_model = 0;

    logic [10:0] dut_word;
    assign dut_word = {out_alufun, out_sign, out_src_b_imm, out_src_a_shamt,
                       out_lui, out_illegal};

    always @(negedge clk) begin
        if (chk_en) begin
            if (!reset) begin
                check("rst_out_valid", {31'd0, out_valid}, 32'd0);
                check("rst_in_ready", {31'd0, in_ready}, 32'd0);
                check("rst_fields", {21'd0, dut_word}, 32'd0);
            end else begin
                check("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
                check("in_ready", {31'd0, in_ready}, {31'd0, armed && q.size() < 2});
                if (q.size() > 0) check("fields", {21'd0, dut_word}, {21'd0, q[0]});
            end
`ifdef ALU_DECODE_ILLEGAL_CNT_EN
            check("illegal_cnt", {16'd0, illegal_cnt}, cnt_model);
`endif
        end
    end

    task automatic step(input logic v, input logic [31:0] ins, input logic ordy);
        bit ix;
        bit ox;
        in_valid  = v;
        in_instr  = ins;
        out_ready = ordy;
        @(posedge clk);
        ix = v && armed && q.size() < 2 && reset;
        ox = ordy && q.size() > 0 && reset;
        if (ox) begin
            if (q[0][0] && cnt_model < 16'hFFFF) cnt_model++;
            void'(q.pop_front());
        end
        if (ix) q.push_back(model(ins));
        if (reset) armed = 1;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        #2 reset = 1'b0;
        #1 check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        q.delete();
        armed     = 0;
        cnt_model = 0;
        in_valid  = 1'b0;
        repeat (n) @(negedge clk);
        #1 reset = 1'b1;
        step(1'b0, 32'd0, 1'b0);
    endtask

    function automatic bit [31:0] rand_instr();
        bit [31:0] ins = $urandom;
        bit [5:0] ops[14] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0C, 6'h0D,
                              6'h0A, 6'h0B, 6'h23, 6'h2B, 6'h0F, 6'h04, 6'h01};
        bit [5:0] fns[14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                              6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08};
        if ($urandom_range(3) != 0) ins[31:26] = ops[$urandom_range(13)];
        if ($urandom_range(3) != 0) ins[5:0] = fns[$urandom_range(13)];
        if ($urandom_range(1) != 0) ins[20:16] = 5'd0;
        if ($urandom_range(7) == 0) ins[31:26] = 6'h05 + 6'($urandom_range(2));
        return ins;
    endfunction

    initial begin
        add(1, 6'h20, 0, 6'b000000, 1, 0, 0, 0);
        add(1, 6'h21, 0, 6'b000000, 0, 0, 0, 0);
        add(1, 6'h22, 0, 6'b000001, 1, 0, 0, 0);
        add(1, 6'h23, 0, 6'b000001, 0, 0, 0, 0);
        add(1, 6'h24, 0, 6'b011000, 0, 0, 0, 0);
        add(1, 6'h25, 0, 6'b011110, 0, 0, 0, 0);
        add(1, 6'h26, 0, 6'b010110, 0, 0, 0, 0);
        add(1, 6'h27, 0, 6'b010001, 0, 0, 0, 0);
        add(1, 6'h2A, 0, 6'b110101, 1, 0, 0, 0);
        add(1, 6'h2B, 0, 6'b110101, 0, 0, 0, 0);
        add(1, 6'h00, 0, 6'b100000, 0, 0, 1, 0);
        add(1, 6'h02, 0, 6'b100001, 0, 0, 1, 0);
        add(1, 6'h03, 0, 6'b100011, 0, 0, 1, 0);
        add(1, 6'h08, 0, 6'b000000, 0, 0, 0, 0);
        add(0, 6'h08, 0, 6'b000000, 1, 1, 0, 0);
        add(0, 6'h09, 0, 6'b000000, 0, 1, 0, 0);
        add(0, 6'h0C, 0, 6'b011000, 0, 1, 0, 0);
        add(0, 6'h0D, 0, 6'b011110, 0, 1, 0, 0);
        add(0, 6'h0A, 0, 6'b110101, 1, 1, 0, 0);
        add(0, 6'h0B, 0, 6'b110101, 0, 1, 0, 0);
        add(0, 6'h23, 0, 6'b000000, 1, 1, 0, 0);
        add(0, 6'h2B, 0, 6'b000000, 1, 1, 0, 0);
        add(0, 6'h0F, 0, 6'b100000, 0, 1, 0, 1);
        add(0, 6'h04, 0, 6'b110011, 1, 0, 0, 0);
        add(0, 6'h05, 0, 6'b110001, 1, 0, 0, 0);
        add(0, 6'h06, 0, 6'b111101, 1, 0, 0, 0);
        add(0, 6'h07, 0, 6'b111111, 1, 0, 0, 0);
        add(0, 6'h01, 1, 6'b111011, 1, 0, 0, 0);

        // Scenario 1: reset held 3 cycles, in_ready one edge after release
        @(negedge clk);
        chk_en = 1;
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        step(1'b0, 32'd0, 1'b0);
        check("s1_in_ready", {31'd0, in_ready}, 32'd1);

        // Scenario 2: add
        step(1'b1, 32'h00851020, 1'b1);
        check("s2_add", {21'd0, dut_word}, {21'd0, 6'b000000, 5'b10000});

        // Scenario 3: sll then lui
        step(1'b1, 32'h00041080, 1'b1);
        check("s3_sll", {21'd0, dut_word}, {21'd0, 6'b100000, 5'b00100});
        step(1'b1, 32'h3C011234, 1'b1);
        check("s3_lui", {21'd0, dut_word}, {21'd0, 6'b100000, 5'b01010});
        step(1'b0, 32'd0, 1'b1);

        // Scenario 4: fill to TWO, third word held, then in-order drain
        step(1'b1, 32'h10850003, 1'b0);
        check("s4_eq", {26'd0, out_alufun}, {26'd0, 6'b110011});
        step(1'b1, 32'h14850003, 1'b0);
        check("s4_full", {31'd0, in_ready}, 32'd0);
        step(1'b1, 32'h00851022, 1'b0);
        check("s4_hold", {26'd0, out_alufun}, {26'd0, 6'b110011});
        step(1'b1, 32'h00851022, 1'b1);
        check("s4_neq", {26'd0, out_alufun}, {26'd0, 6'b110001});
        step(1'b1, 32'h00851022, 1'b1);
        check("s4_third", {26'd0, out_alufun}, {26'd0, 6'b000001});
        step(1'b0, 32'd0, 1'b1);
        check("s4_empty", {31'd0, out_valid}, 32'd0);

        // Scenario 5: illegal opcode
        step(1'b1, 32'hFC000000, 1'b1);
        check("s5_illegal", {21'd0, dut_word}, {21'd0, 6'b000000, 5'b00001});
        step(1'b0, 32'd0, 1'b1);
`ifdef ALU_DECODE_ILLEGAL_CNT_EN
        check("s5_cnt", {16'd0, illegal_cnt}, 32'd1);
`endif

        // Scenario 6: reset while TWO
        step(1'b1, 32'h10850003, 1'b0);
        step(1'b1, 32'h14850003, 1'b0);
        do_reset(2);
        check("s6_no_stale", {31'd0, out_valid}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(399) == 0) begin
                do_reset(1 + $urandom_range(2));
            end else begin
                step($urandom_range(3) != 0, rand_instr(), $urandom_range(2) != 0);
            end
        end
        repeat (4) step(1'b0, 32'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; ports are listed clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-004 in_valid  input  1  upstream instruction word present.
REQ-005 in_ready  output  1  stage can accept a word this cycle.
REQ-006 in_instr  input  32  MIPS instruction; opcode [31:26], rt [20:16], funct [5:0].
REQ-007 out_valid  output  1  decoded control word present.
REQ-008 out_ready  input  1  downstream ALU stage accepts this cycle.
REQ-009 out_alufun  output  6  ALU function code driven to the ALU's ALUFun input.
REQ-010 out_sign  output  1  signed-arithmetic flag driven to the ALU's Sign input.
REQ-011 out_src_b_imm  output  1  1 = operand B is the extended immediate.
REQ-012 out_src_a_shamt  output  1  1 = operand A is instr[10:6] (shift amount).
REQ-013 out_lui  output  1  1 = operand A is constant 16 and operand B is the immediate (LUI).
REQ-014 out_illegal  output  1  instruction not in the decode table.

Function
REQ-015 Code table: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111.
REQ-016 Opcode 0x00 funct map: 20 ADD s1; 21 ADD s0; 22 SUB s1; 23 SUB s0; 24 AND; 25 OR; 26 XOR; 27 NOR; 2A LT s1; 2B LT s0; 00/02/03 SLL/SRL/SRA with src_a_shamt=1; 08 ADD s0.
REQ-017 I-type map, all src_b_imm=1: 08 ADD s1; 09 ADD s0; 0C AND; 0D OR; 0A LT s1; 0B LT s0; 23/2B ADD s1; 0F SLL with lui=1.
REQ-018 Branch map, src_b_imm=0, sign=1: 04 EQ; 05 NEQ; 06 LEZ; 07 GTZ; 01 with rt=0 LTZ.
REQ-019 Unlisted combinations: alufun=ADD, sign=0, all selects 0, illegal=1.
REQ-020 Logic and shift ops SHALL drive sign=0.
REQ-021 An input transfer occurs when in_valid and in_ready are both 1; an output transfer occurs when out_valid and out_ready are both 1.
REQ-022 Latency: a word accepted at edge N SHALL appear at the outputs after edge N, provided the output register is empty or drains at edge N.
REQ-023 Buffering: 2-entry skid (output register plus skid register). States EMPTY, ONE and TWO.
REQ-024 EMPTY: in transfer -> ONE.
REQ-025 ONE: in transfer with no out transfer -> TWO, with the new word held in the skid register.
REQ-026 ONE: in transfer with out transfer -> ONE, with the new word loaded into the output register.
REQ-027 ONE: out transfer only -> EMPTY.
REQ-028 TWO: out transfer -> ONE, with the skid word moved to the output register; no input is accepted in TWO.
REQ-029 in_ready SHALL be a registered signal, equal to 1 exactly when the state is not TWO; it never depends combinationally on out_ready.
REQ-030 Output fields SHALL hold stable while out_valid=1 and out_ready=0.
REQ-031 Words SHALL leave in acceptance order with no loss or duplication.
REQ-032 While out_valid=0, the output fields are don't-care but SHALL NOT be X after reset.

Reset
REQ-033 While reset=0: state EMPTY, out_valid=0, in_ready=0, all output fields 0, skid register 0.
REQ-034 in_ready SHALL rise at the first clk edge after reset deasserts.
REQ-035 Reset asserted mid-transfer SHALL discard both entries immediately, without waiting for a clock edge.

Configuration
REQ-036 Macro ALU_DECODE_ILLEGAL_CNT_EN: when defined, the block SHALL add output illegal_cnt (16 bits).
REQ-037 illegal_cnt SHALL increment on each output transfer with out_illegal=1.
REQ-038 illegal_cnt SHALL saturate at 0xFFFF and reset to 0.
REQ-039 Without ALU_DECODE_ILLEGAL_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-040 Scenario 1: reset low 3 cycles, then high -> out_valid=0 throughout reset; in_ready=1 one edge after release.
REQ-041 Scenario 2: 0x00851020 (add), out_ready=1 -> next cycle alufun=000000, sign=1, src_b_imm=0, illegal=0.
REQ-042 Scenario 3: 0x00041080 (sll) then 0x3C011234 (lui) -> first SLL with src_a_shamt=1; second SLL with lui=1 and src_b_imm=1.
REQ-043 Scenario 4: out_ready=0, stream beq 0x10850003 then bne 0x14850003 -> state TWO and in_ready=0; a third word is held.
REQ-044 Scenario 4, continued: out_ready=1 -> EQ (110011), then NEQ (110001), then the third word, in order.
REQ-045 Scenario 5: opcode 0x3F -> alufun=000000, illegal=1; with ALU_DECODE_ILLEGAL_CNT_EN, illegal_cnt goes 0 -> 1.
REQ-046 Scenario 6: reset asserted while in TWO -> out_valid=0 immediately; no stale word appears after release.
